// File: rtl/bfly_pkg.sv
// Shared defaults and the round/saturate helper for the butterfly twiddle
// multiplier.
package bfly_pkg;

  localparam int BFLY_W  = 10;  // data width, signed <4.6>
  localparam int TW_W    = 9;   // twiddle width, signed <2.7>
  localparam int SCALE_W = 7;   // twiddle fractional bits
  localparam int N_LANES = 16;  // butterfly lanes per beat

  // Round-half-up then clamp (sat_en=1) or wrap (sat_en=0) to out_w bits.
  // x carries an in_w-bit signed value in its low bits; the result is
  // sign-extended to 64 bits so the caller just takes the low out_w bits.
  // hit reports that a clamp happened.
  function automatic logic signed [63:0] sat_round(
    input  logic signed [63:0] x,
    input  int                 in_w,
    input  int                 out_w,
    input  int                 scale,
    input  logic               sat_en,
    output logic               hit
  );
    logic signed [63:0] xs, r, hi, lo;
    xs  = (x <<< (64 - in_w)) >>> (64 - in_w);
    r   = (xs + (64'sd1 <<< (scale - 1))) >>> scale;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (out_w - 1));
    hit = 1'b0;
    if (sat_en && (r > hi)) begin
      hit = 1'b1;
      r   = hi;
    end else if (sat_en && (r < lo)) begin
      hit = 1'b1;
      r   = lo;
    end else begin
      r = (r <<< (64 - out_w)) >>> (64 - out_w);
    end
    return r;
  endfunction

endpackage

// File: rtl/bfly_cmul_lane.sv
// One butterfly lane: S1 registers the four partial products, S2 combines,
// rounds, saturates (BFLY_MUL_SAT_EN) or wraps, and registers the result.
// conj/bypass arrive already aligned with the S1 products.
module bfly_cmul_lane
  import bfly_pkg::*;
#(
  parameter int BFLY  = BFLY_W,
  parameter int TW    = TW_W,
  parameter int SCALE = SCALE_W
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   conj,
  input  logic                   bypass,
  input  logic signed [BFLY-1:0] a,
  input  logic signed [BFLY-1:0] b,
  input  logic signed [TW-1:0]   c,
  input  logic signed [TW-1:0]   d,
  output logic signed [BFLY-1:0] out_re,
  output logic signed [BFLY-1:0] out_im,
  output logic                   sat
);

  localparam int PW = BFLY + TW;  // single product width
  localparam int SW = PW + 1;     // combined sum width

`ifdef BFLY_MUL_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic signed [PW-1:0]   ac, bd, ad, bc;
  logic signed [BFLY-1:0] a_q, b_q;
  logic signed [SW-1:0]   sum_re, sum_im;
  logic signed [63:0]     rnd_re, rnd_im;
  logic                   hit_re, hit_im;
  logic signed [BFLY-1:0] res_re, res_im;

  // S1: partial products plus raw input kept for bypass
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ac  <= '0;
      bd  <= '0;
      ad  <= '0;
      bc  <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (en) begin
      ac  <= PW'(a) * PW'(c);
      bd  <= PW'(b) * PW'(d);
      ad  <= PW'(a) * PW'(d);
      bc  <= PW'(b) * PW'(c);
      a_q <= a;
      b_q <= b;
    end
  end

  // Combine: conj swaps signs on the products instead of negating tw_im,
  // so tw_im = -2^(TW-1) never overflows.
  always_comb begin
    sum_re = '0;
    sum_im = '0;
    hit_re = 1'b0;
    hit_im = 1'b0;
    if (conj) begin
      sum_re = SW'(ac) + SW'(bd);
      sum_im = SW'(bc) - SW'(ad);
    end else begin
      sum_re = SW'(ac) - SW'(bd);
      sum_im = SW'(ad) + SW'(bc);
    end
    rnd_re = sat_round(64'(sum_re), SW, BFLY, SCALE, SAT_EN, hit_re);
    rnd_im = sat_round(64'(sum_im), SW, BFLY, SCALE, SAT_EN, hit_im);
    res_re = bypass ? a_q : rnd_re[BFLY-1:0];
    res_im = bypass ? b_q : rnd_im[BFLY-1:0];
    sat    = !bypass && (hit_re || hit_im);
  end

  // S2: output register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_re <= '0;
      out_im <= '0;
    end else if (en) begin
      out_re <= res_re;
      out_im <= res_im;
    end
  end

endmodule

// File: rtl/bfly_cmul_pipe.sv
// Two-stage N-lane complex twiddle multiplier with valid/ready flow control.
// Optional macro BFLY_MUL_SAT_EN: saturating outputs and a live sticky
// sat_flag; without it results wrap and sat_flag is tied low.
// Both stages advance together (en); bubbles in S1 are not squeezed out
// during a stall, so at most two beats are ever in flight.
module bfly_cmul_pipe
  import bfly_pkg::*;
#(
  parameter int BFLY  = BFLY_W,
  parameter int TW    = TW_W,
  parameter int SCALE = SCALE_W,
  parameter int N     = N_LANES
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_conj,
  input  logic                   in_bypass,
  input  logic [N-1:0][BFLY-1:0] bfly_re,
  input  logic [N-1:0][BFLY-1:0] bfly_im,
  input  logic [N-1:0][TW-1:0]   tw_re,
  input  logic [N-1:0][TW-1:0]   tw_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0][BFLY-1:0] out_re,
  output logic [N-1:0][BFLY-1:0] out_im,
  output logic                   sat_flag,
  input  logic                   sat_clr
);

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic            en;
  logic            conj_s1, byp_s1;
  logic [N-1:0]    lane_sat;

  assign en        = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  // Valid shift register, advances with the datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // Mode bits travel alongside the S1 products
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      conj_s1 <= 1'b0;
      byp_s1  <= 1'b0;
    end else if (en) begin
      conj_s1 <= in_conj;
      byp_s1  <= in_bypass;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    bfly_cmul_lane #(
      .BFLY  (BFLY),
      .TW    (TW),
      .SCALE (SCALE)
    ) u_lane (
      .clk    (clk),
      .rstn   (rstn),
      .en     (en),
      .conj   (conj_s1),
      .bypass (byp_s1),
      .a      (bfly_re[i]),
      .b      (bfly_im[i]),
      .c      (tw_re[i]),
      .d      (tw_im[i]),
      .out_re (out_re[i]),
      .out_im (out_im[i]),
      .sat    (lane_sat[i])
    );
  end

`ifdef BFLY_MUL_SAT_EN
  // Sticky saturation flag; a new clamp in the same cycle beats the clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sat_flag <= 1'b0;
    else if (en && vld_pipe[1] && (|lane_sat)) sat_flag <= 1'b1;
    else if (sat_clr) sat_flag <= 1'b0;
  end
`else
  logic unused_sat;
  assign unused_sat = sat_clr | (|lane_sat);
  assign sat_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_bfly_cmul_pipe.sv
// Scoreboard bench for bfly_cmul_pipe: expected beats are modelled and queued
// at the input handshake and popped when the output handshakes.
module tb_bfly_cmul_pipe;

  localparam int N     = 16;
  localparam int BFLY  = 10;
  localparam int TW    = 9;
  localparam int SCALE = 7;

  typedef logic [N-1:0][BFLY-1:0] dvec_t;
  typedef logic [N-1:0][TW-1:0]   tvec_t;
  typedef struct {
    dvec_t re;
    dvec_t im;
    logic  sat;
    int    due;
  } exp_t;

  logic  clk = 1'b0;
  logic  rstn;
  logic  in_valid, in_ready, in_conj, in_bypass;
  dvec_t bfly_re, bfly_im;
  tvec_t tw_re, tw_im;
  logic  out_valid, out_ready;
  dvec_t out_re, out_im;
  logic  sat_flag, sat_clr;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sbq[$];
  logic exp_flag;

`ifdef BFLY_MUL_SAT_EN
  localparam logic SAT_ON = 1'b1;
`else
  localparam logic SAT_ON = 1'b0;
`endif

  bfly_cmul_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_conj   (in_conj),
    .in_bypass (in_bypass),
    .bfly_re   (bfly_re),
    .bfly_im   (bfly_im),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .sat_flag  (sat_flag),
    .sat_clr   (sat_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  function automatic dvec_t rep_d(input int v);
    dvec_t r;
    for (int i = 0; i < N; i++) r[i] = v[BFLY-1:0];
    return r;
  endfunction

  function automatic tvec_t rep_t(input int v);
    tvec_t r;
    for (int i = 0; i < N; i++) r[i] = v[TW-1:0];
    return r;
  endfunction

  // Bring a rounded value into range: clamp when saturating, else wrap modulo 2^BFLY
  function automatic longint fit(input longint x, output logic hit);
    longint m, hi, lo, y;
    m  = longint'(1) << BFLY;
    hi = m / 2 - 1;
    lo = -(m / 2);
    hit = 1'b0;
    y = x;
    if (SAT_ON) begin
      if (x > hi) begin y = hi; hit = 1'b1; end
      if (x < lo) begin y = lo; hit = 1'b1; end
    end else begin
      y = x % m;
      if (y < 0) y = y + m;
      if (y > hi) y = y - m;
    end
    return y;
  endfunction

  function automatic exp_t model(input dvec_t a, input dvec_t b, input tvec_t c,
                                 input tvec_t d, input logic cj, input logic by);
    exp_t   m;
    longint ai, bi, ci, di, sr, si, rr, ri;
    logic   h1, h2;
    m.sat = 1'b0;
    m.due = 0;
    for (int i = 0; i < N; i++) begin
      ai = longint'($signed(a[i]));
      bi = longint'($signed(b[i]));
      ci = longint'($signed(c[i]));
      di = longint'($signed(d[i]));
      if (by) begin
        m.re[i] = a[i];
        m.im[i] = b[i];
      end else begin
        sr = cj ? (ai * ci + bi * di) : (ai * ci - bi * di);
        si = cj ? (bi * ci - ai * di) : (ai * di + bi * ci);
        // floor((s + half) / 2^SCALE)
        rr = (sr + (longint'(1) << (SCALE - 1))) >>> SCALE;
        ri = (si + (longint'(1) << (SCALE - 1))) >>> SCALE;
        rr = fit(rr, h1);
        ri = fit(ri, h2);
        m.re[i] = rr[BFLY-1:0];
        m.im[i] = ri[BFLY-1:0];
        m.sat = m.sat | h1 | h2;
      end
    end
    return m;
  endfunction

  // Drive one cycle of inputs at the falling edge; queue the expected beat on handshake
  task automatic drive(input logic v, input dvec_t a, input dvec_t b, input tvec_t c,
                       input tvec_t d, input logic cj, input logic by,
                       input logic ordy, input logic clr, output logic hs);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    bfly_re   = a;
    bfly_im   = b;
    tw_re     = c;
    tw_im     = d;
    in_conj   = cj;
    in_bypass = by;
    out_ready = ordy;
    sat_clr   = clr;
    #1;
    hs = v && in_ready;
    if (hs) begin
      e = model(a, b, c, d, cj, by);
      e.due = cyc + 2;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input logic ordy, input logic clr);
    logic hs;
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, ordy, clr, hs);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    in_valid = 1'b0; in_conj = 1'b0; in_bypass = 1'b0;
    bfly_re = '0; bfly_im = '0; tw_re = '0; tw_im = '0;
    out_ready = 1'b1; sat_clr = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_re !== '0 || out_im !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b re=%h im=%h want 0", out_valid, out_re, out_im);
    end
    total++;
    if (sat_flag !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_flags: got sat_flag=%b in_ready=%b want 0/1", sat_flag, in_ready);
    end
    rstn = 1'b1;
    idle(1'b1, 1'b0);
  endtask

  // Identity, rotation by j, conj rotation and rounding, back to back
  task automatic test_arith();
    int   are[5] = '{100, 100, 100, 3, 1};
    int   aim[5] = '{-50, -50, -50, -3, 0};
    int   cre[5] = '{128, 0, 0, 64, 64};
    int   cim[5] = '{0, 128, 128, 0, 0};
    int   cjv[5] = '{0, 0, 1, 0, 0};
    int   xre[5] = '{100, 50, -50, 2, 1};
    int   xim[5] = '{-50, 100, -100, -1, 0};
    int   k = 0;
    int   p = 0;
    logic hs;
    exp_t e;
    for (int c = 0; c < 12; c++) begin
      if (k < 5)
        drive(1'b1, rep_d(are[k]), rep_d(aim[k]), rep_t(cre[k]), rep_t(cim[k]),
              cjv[k] != 0, 1'b0, 1'b1, 1'b0, hs);
      else
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, hs);
      if (hs) k++;
      if (out_valid && out_ready) begin
        total++;
        if (sbq.size() == 0 || p >= 5) begin
          bad++;
          $display("FAIL arith_extra: unexpected output beat re=%h", out_re);
        end else begin
          e = sbq.pop_front();
          if (out_re !== e.re || out_im !== e.im || out_re !== rep_d(xre[p]) ||
              out_im !== rep_d(xim[p])) begin
            bad++;
            $display("FAIL arith_data beat=%0d: got re=%h im=%h want re=%h im=%h",
                     p, out_re, out_im, rep_d(xre[p]), rep_d(xim[p]));
          end
          total++;
          if (cyc !== e.due) begin
            bad++;
            $display("FAIL arith_latency beat=%0d: got cycle %0d want %0d", p, cyc, e.due);
          end
          p++;
        end
      end
    end
    total++;
    if (p !== 5 || sbq.size() !== 0) begin
      bad++;
      $display("FAIL arith_count: got %0d outputs want 5", p);
    end
  endtask

  task automatic test_saturation();
    logic hs;
    exp_t e;
    int   p = 0;
    int   xim = SAT_ON ? 511 : -12;
    idle(1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      if (c == 0)
        drive(1'b1, rep_d(511), rep_d(511), rep_t(255), rep_t(255), 1'b0, 1'b0, 1'b1, 1'b0, hs);
      else
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, hs);
      if (out_valid && out_ready) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL sat_extra: unexpected output beat");
        end else begin
          e = sbq.pop_front();
          p++;
          if (out_re !== e.re || out_im !== e.im || out_re !== rep_d(0) || out_im !== rep_d(xim)) begin
            bad++;
            $display("FAIL sat_data: got re=%h im=%h want re=%h im=%h",
                     out_re, out_im, rep_d(0), rep_d(xim));
          end
          total++;
          if (sat_flag !== SAT_ON) begin
            bad++;
            $display("FAIL sat_flag_set: got %b want %b", sat_flag, SAT_ON);
          end
        end
      end
    end
    total++;
    if (p !== 1) begin
      bad++;
      $display("FAIL sat_count: got %0d outputs want 1", p);
    end
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    total++;
    if (sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL sat_flag_clr: got %b want 0", sat_flag);
    end
  endtask

  task automatic test_backpressure();
    logic  hs;
    exp_t  e;
    int    k = 0;
    int    p = 0;
    dvec_t held;
    held = '0;
    for (int c = 0; c < 16; c++) begin
      if (k < 4)
        drive(1'b1, rep_d(10 * (k + 1)), rep_d(-k - 1), rep_t(128), rep_t(0),
              1'b0, 1'b0, !(c >= 2 && c <= 5), 1'b0, hs);
      else
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, !(c >= 2 && c <= 5), 1'b0, hs);
      if (hs) k++;
      if (c == 2) held = out_re;
      if (c == 5) begin
        total++;
        if (k !== 2 || in_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_accept: got accepted=%0d in_ready=%b want 2/0", k, in_ready);
        end
        total++;
        if (out_valid !== 1'b1 || out_re !== held || held !== rep_d(10)) begin
          bad++;
          $display("FAIL bp_hold: got valid=%b re=%h want re=%h", out_valid, out_re, rep_d(10));
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL bp_extra: unexpected output beat re=%h", out_re);
        end else begin
          e = sbq.pop_front();
          if (out_re !== e.re || out_im !== e.im || out_re !== rep_d(10 * (p + 1))) begin
            bad++;
            $display("FAIL bp_order beat=%0d: got re=%h im=%h want re=%h im=%h",
                     p, out_re, out_im, e.re, e.im);
          end
          p++;
        end
      end
    end
    total++;
    if (p !== 4 || sbq.size() !== 0) begin
      bad++;
      $display("FAIL bp_count: got %0d outputs want 4", p);
    end
  endtask

  task automatic test_random();
    logic        hs;
    exp_t        e;
    dvec_t       a, b;
    tvec_t       c, d;
    logic [31:0] t;
    int          sent = 0;
    int          p = 0;
    idle(1'b1, 1'b1);
    exp_flag = 1'b0;
    for (int cy = 0; cy < 320; cy++) begin
      for (int i = 0; i < N; i++) begin
        t = $urandom(); a[i] = t[BFLY-1:0];
        t = $urandom(); b[i] = t[BFLY-1:0];
        t = $urandom(); c[i] = t[TW-1:0];
        t = $urandom(); d[i] = t[TW-1:0];
      end
      drive((cy < 300) && ($urandom_range(0, 3) != 0), a, b, c, d,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            (cy >= 300) || ($urandom_range(0, 3) != 0), 1'b0, hs);
      if (hs) sent++;
      if (out_valid && out_ready) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL rand_extra: unexpected output beat re=%h", out_re);
        end else begin
          e = sbq.pop_front();
          p++;
          exp_flag = exp_flag | e.sat;
          if (out_re !== e.re || out_im !== e.im) begin
            bad++;
            $display("FAIL rand_data beat=%0d: got re=%h im=%h want re=%h im=%h",
                     p, out_re, out_im, e.re, e.im);
          end
          total++;
          if (sat_flag !== exp_flag) begin
            bad++;
            $display("FAIL rand_sat_flag beat=%0d: got %b want %b", p, sat_flag, exp_flag);
          end
        end
      end
    end
    total++;
    if (p !== sent || sbq.size() !== 0) begin
      bad++;
      $display("FAIL rand_count: got %0d outputs want %0d", p, sent);
    end
  endtask

  task automatic test_bypass_reset();
    logic hs;
    exp_t e;
    int   p = 0;
    idle(1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 0)
        drive(1'b1, rep_d(-512), rep_d(511), rep_t(255), rep_t(255), 1'b0, 1'b1, 1'b1, 1'b0, hs);
      else
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, hs);
      if (out_valid && out_ready) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL byp_extra: unexpected output beat");
        end else begin
          e = sbq.pop_front();
          p++;
          if (out_re !== e.re || out_im !== e.im || out_re !== rep_d(-512) ||
              out_im !== rep_d(511) || sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL byp_data: got re=%h im=%h sat=%b want re=%h im=%h sat=0",
                     out_re, out_im, sat_flag, rep_d(-512), rep_d(511));
          end
        end
      end
    end
    total++;
    if (p !== 1) begin
      bad++;
      $display("FAIL byp_count: got %0d outputs want 1", p);
    end
    // Two beats in flight, then reset
    drive(1'b1, rep_d(7), rep_d(8), rep_t(128), rep_t(0), 1'b0, 1'b0, 1'b1, 1'b0, hs);
    drive(1'b1, rep_d(9), rep_d(10), rep_t(128), rep_t(0), 1'b0, 1'b0, 1'b1, 1'b0, hs);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_inflight: got out_valid=%b want 1", out_valid);
    end
    rstn = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_re !== '0 || out_im !== '0) begin
      bad++;
      $display("FAIL rst_flush: got valid=%b re=%h want 0", out_valid, out_re);
    end
    sbq.delete();
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      idle(1'b1, 1'b0);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_drop: got out_valid=%b after reset want 0", out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_saturation();
    test_backpressure();
    test_random();
    test_bypass_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
